bus_sync_tx: RTL and testbench

Source-domain sender for a toggle request/acknowledge bus crossing. Accepts a word on a valid/ready handshake in the `src_clk` domain and registers it. It drives a data bus that stays stable and a level request toggle toward the destination domain. It then waits for the destination's echoed acknowledge toggle before it accepts the next word. It is the transmit end paired with the destination-side capture logic; all logic runs on one clock.

---
 rtl/bus_sync_tx.sv | 112 +++++++++++
 tb/tb_bus_sync_tx.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sync_tx.sv
// Source-side sender of a toggle request/acknowledge bus crossing.
// Holds one word on req_data, flips req_tgl per word, waits for the echoed toggle.
module bus_sync_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GAP        = 0,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  src_clk,
  input  logic                  src_rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
  output logic                  din_rdy,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_tgl,
  input  logic                  ack_tgl_sync,
  output logic                  done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  sent_cnt,
  output logic                  err_timeout,
  output logic                  err_proto,
  input  logic                  err_clr
);

  localparam int unsigned TO_W  = 16;
  localparam int unsigned GAP_W = 4;

  localparam logic [TO_W-1:0]  TO_MAX   = '1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam bit               GAP_EN   = (GAP != 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_GAP      = 2'd2
  } state_t;

  state_t           state;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic ack_match;
  logic to_set;
  logic proto_set;

  // The echo matching our level means the destination has captured req_data.
  assign ack_match = (ack_tgl_sync == req_tgl);
  assign to_set    = TO_EN && (state == S_WAIT_ACK) && !ack_match && (to_cnt == TO_LAST);
  assign proto_set = (state == S_IDLE) && !ack_match;

  assign din_rdy = (state == S_IDLE) && !src_rst;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state       <= S_IDLE;
      req_data    <= '0;
      req_tgl     <= 1'b0;
      done        <= 1'b0;
      sent_cnt    <= '0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;

      // Sticky flags: a new set beats a simultaneous clear.
      err_timeout <= to_set    || (err_timeout && !err_clr);
      err_proto   <= proto_set || (err_proto   && !err_clr);

      case (state)
        S_IDLE: begin
          if (din_vld) begin
            req_data <= din;
            req_tgl  <= ~req_tgl;
            to_cnt   <= '0;
            state    <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          if (ack_match) begin
            done     <= 1'b1;
            sent_cnt <= sent_cnt + CNT_WIDTH'(1);
            if (GAP_EN) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              state   <= S_IDLE;
            end
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sync_tx.sv
// Bench for bus_sync_tx: two instances (GAP 0 and GAP 4) checked every cycle
// against a behavioural model, plus directed literal checks.
module tb_bus_sync_tx;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam int          TMO = 16;

  logic          clk;
  logic          rst;
  logic          clr;
  logic [DW-1:0] din    [2];
  logic          vld    [2];
  logic          rdy    [2];
  logic [DW-1:0] rdata  [2];
  logic          rtgl   [2];
  logic          ack    [2];
  logic          done_o [2];
  logic          busy_o [2];
  logic [CW-1:0] cnt    [2];
  logic          eto    [2];
  logic          epr    [2];

  logic amode [2];
  logic afix  [2];
  int   adly  [2];

  int total;
  int bad;
  bit rdone;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_sync_tx #(.DATA_WIDTH(DW), .GAP(0), .TIMEOUT(TMO), .CNT_WIDTH(CW)) u0 (
    .src_clk(clk), .src_rst(rst), .din(din[0]), .din_vld(vld[0]), .din_rdy(rdy[0]),
    .req_data(rdata[0]), .req_tgl(rtgl[0]), .ack_tgl_sync(ack[0]), .done(done_o[0]),
    .busy(busy_o[0]), .sent_cnt(cnt[0]), .err_timeout(eto[0]), .err_proto(epr[0]),
    .err_clr(clr));

  bus_sync_tx #(.DATA_WIDTH(DW), .GAP(4), .TIMEOUT(TMO), .CNT_WIDTH(CW)) u1 (
    .src_clk(clk), .src_rst(rst), .din(din[1]), .din_vld(vld[1]), .din_rdy(rdy[1]),
    .req_data(rdata[1]), .req_tgl(rtgl[1]), .ack_tgl_sync(ack[1]), .done(done_o[1]),
    .busy(busy_o[1]), .sent_cnt(cnt[1]), .err_timeout(eto[1]), .err_proto(epr[1]),
    .err_clr(clr));

  // Destination stand-in: echoes req_tgl after adly extra cycles, or a fixed level.
  for (genvar g = 0; g < 2; g++) begin : g_loop
    logic [2:0] hist;
    always @(posedge clk) begin
      if (rst) hist <= '0;
      else     hist <= {hist[1:0], rtgl[g]};
    end
    assign ack[g] = amode[g] ? afix[g] :
                    (adly[g] == 0) ? rtgl[g] : hist[2'(adly[g] - 1)];
  end

  task automatic check(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input int i);
    total++;
    bad++;
    $display("FAIL %s[%0d] bound expired t=%0t", nm, i, $time);
  endtask

  // Behavioural model: a word is outstanding until the echo matches, then
  // the block rests GAP cycles; waiting cycles are counted against TIMEOUT.
  bit            m_valid;
  bit            m_pend [2];
  int            m_gap  [2];
  int            m_wait [2];
  int            m_cnt  [2];
  logic [DW-1:0] m_data [2];
  bit            m_tgl  [2];
  bit            m_done [2];
  bit            m_to   [2];
  bit            m_pr   [2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  always @(posedge clk) begin
    bit free_m;
    bit s_to;
    bit s_pr;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pend[i] = 0; m_gap[i] = 0; m_wait[i] = 0; m_cnt[i] = 0;
        m_data[i] = '0; m_tgl[i] = 0; m_done[i] = 0; m_to[i] = 0; m_pr[i] = 0;
      end else begin
        free_m    = !m_pend[i] && (m_gap[i] == 0);
        s_to      = 0;
        s_pr      = 0;
        m_done[i] = 0;
        if (free_m) begin
          if (ack[i] != m_tgl[i]) s_pr = 1;
          if (vld[i]) begin
            m_data[i] = din[i];
            m_tgl[i]  = !m_tgl[i];
            m_pend[i] = 1;
            m_wait[i] = 0;
          end
        end else if (m_pend[i]) begin
          if (ack[i] == m_tgl[i]) begin
            m_done[i] = 1;
            m_cnt[i]  = (m_cnt[i] + 1) % (1 << CW);
            m_pend[i] = 0;
            m_gap[i]  = gap_of(i);
          end else begin
            m_wait[i]++;
            if (m_wait[i] == TMO) s_to = 1;
          end
        end else begin
          m_gap[i]--;
        end
        m_to[i] = s_to || (m_to[i] && !clr);
        m_pr[i] = s_pr || (m_pr[i] && !clr);
      end
    end
    if (rst) m_valid = 1;
    #1;
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        check("din_rdy",     i, 32'(rdy[i]),    32'(!rst && !m_pend[i] && m_gap[i] == 0));
        check("busy",        i, 32'(busy_o[i]), 32'(m_pend[i] || m_gap[i] != 0));
        check("req_data",    i, rdata[i],       m_data[i]);
        check("req_tgl",     i, 32'(rtgl[i]),   32'(m_tgl[i]));
        check("done",        i, 32'(done_o[i]), 32'(m_done[i]));
        check("sent_cnt",    i, 32'(cnt[i]),    32'(m_cnt[i]));
        check("err_timeout", i, 32'(eto[i]),    32'(m_to[i]));
        check("err_proto",   i, 32'(epr[i]),    32'(m_pr[i]));
      end
    end
  end

  // Offer w and hold valid until an edge accepts it; k = edges waited.
  task automatic send_word(input int i, input logic [31:0] w, output int k, output bit ok);
    ok = 0;
    k  = 0;
    @(negedge clk);
    din[i] = w;
    vld[i] = 1'b1;
    while (!ok && k < 300) begin
      @(posedge clk);
      k++;
      if (rdy[i]) ok = 1;
    end
    if (!ok) begin
      fail_now("accept", i);
      vld[i] = 1'b0;
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (done_o[i]) ok = 1;
    end
    if (!ok) fail_now("wait_done", i);
  endtask

  task automatic wait_rdy(input int i);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (rdy[i]) ok = 1;
    end
    if (!ok) fail_now("wait_rdy", i);
  endtask

  task automatic rand_run(input int i, input int n);
    int k;
    bit ok;
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle(i);
        wait_rdy(i);
        amode[i] = 1'b1;
        afix[i]  = rtgl[i];
        send_word(i, $urandom, k, ok);
        idle(i);
        repeat ($urandom_range(5, 24)) @(negedge clk);
        afix[i] = !afix[i];
        wait_done(i);
        repeat (4) @(negedge clk);
        amode[i] = 1'b0;
      end else begin
        send_word(i, $urandom, k, ok);
        if ($urandom_range(0, 2) == 0) begin
          idle(i);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    end
    idle(i);
  endtask

  initial begin
    int k;
    bit ok;
    total = 0;
    bad   = 0;
    rdone = 0;
    m_valid = 0;
    rst = 1'b1;
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; vld[i] = 1'b0; amode[i] = 1'b0; afix[i] = 1'b0; adly[i] = 3;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_tgl",  0, 32'(rtgl[0]), 32'h0);
    check("rst_cnt",  0, 32'(cnt[0]),  32'h0);
    check("rst_busy", 1, 32'(busy_o[1]), 32'h0);

    // Basic transfer, loopback delayed 3.
    send_word(0, 32'hDEADBEEF, k, ok);
    #1;
    check("basic_tgl",  0, 32'(rtgl[0]), 32'h1);
    check("basic_data", 0, rdata[0], 32'hDEADBEEF);
    idle(0);
    wait_done(0);
    check("basic_cnt",  0, 32'(cnt[0]), 32'h1);
    check("basic_rdy",  0, 32'(rdy[0]), 32'h1);
    check("basic_hold", 0, rdata[0], 32'hDEADBEEF);

    // Back-to-back with immediate echo: two-cycle spacing.
    @(negedge clk);
    adly[0] = 0;
    send_word(0, 32'h1, k, ok);
    send_word(0, 32'h2, k, ok);
    check("b2b_space2", 0, 32'(k), 32'd2);
    send_word(0, 32'h3, k, ok);
    check("b2b_space3", 0, 32'(k), 32'd2);
    idle(0);
    wait_done(0);
    check("b2b_cnt",  0, 32'(cnt[0]), 32'h4);
    check("b2b_data", 0, rdata[0], 32'h3);

    // GAP=4 instance with loopback delayed 2: 8-cycle spacing.
    @(negedge clk);
    adly[1] = 2;
    send_word(1, 32'hA1, k, ok);
    send_word(1, 32'hA2, k, ok);
    check("gap_space2", 1, 32'(k), 32'd8);
    send_word(1, 32'hA3, k, ok);
    check("gap_space3", 1, 32'(k), 32'd8);
    idle(1);
    wait_done(1);
    check("gap_cnt", 1, 32'(cnt[1]), 32'h3);

    // Timeout: echo withheld.
    @(negedge clk);
    amode[0] = 1'b1;
    afix[0]  = rtgl[0];
    send_word(0, 32'h5A5A0001, k, ok);
    idle(0);
    ok = 0;
    for (k = 1; k <= 40 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (eto[0]) ok = 1;
    end
    check("to_edges", 0, 32'(k - 1), 32'd16);
    check("to_frozen", 0, rdata[0], 32'h5A5A0001);
    @(negedge clk);
    afix[0] = !afix[0];
    wait_done(0);
    check("to_cnt", 0, 32'(cnt[0]), 32'h5);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    check("to_cleared", 0, 32'(eto[0]), 32'h0);
    send_word(0, 32'h5A5A0002, k, ok);
    repeat (15) @(posedge clk);
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1;
    check("to_set_wins", 0, 32'(eto[0]), 32'h1);
    @(negedge clk);
    clr = 1'b0;
    vld[0] = 1'b0;
    afix[0] = !afix[0];
    wait_done(0);

    // Protocol error in IDLE, then a word is still accepted.
    @(negedge clk) afix[0] = !rtgl[0];
    @(posedge clk);
    #1;
    check("proto_set", 0, 32'(epr[0]), 32'h1);
    @(negedge clk) afix[0] = rtgl[0];
    send_word(0, 32'hC0DE, k, ok);
    check("proto_accept", 0, 32'(ok), 32'h1);
    idle(0);
    afix[0] = !afix[0];
    wait_done(0);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;

    // Reset in the middle of WAIT_ACK.
    send_word(0, 32'hBAD0BAD0, k, ok);
    idle(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    amode[0] = 1'b0;
    adly[0] = 0;
    @(posedge clk);
    #1;
    check("mid_rst_data", 0, rdata[0], 32'h0);
    check("mid_rst_tgl",  0, 32'(rtgl[0]), 32'h0);
    check("mid_rst_cnt",  0, 32'(cnt[0]), 32'h0);
    check("mid_rst_rdy",  0, 32'(rdy[0]), 32'h0);
    check("mid_rst_busy", 0, 32'(busy_o[0]), 32'h0);
    @(negedge clk) rst = 1'b0;

    // 17 transfers wrap a 4-bit counter to 1.
    for (int j = 0; j < 17; j++) send_word(0, 32'(j + 100), k, ok);
    idle(0);
    wait_done(0);
    check("wrap_cnt", 0, 32'(cnt[0]), 32'h1);

    // Randomized traffic on both instances with random clears.
    repeat (6) @(negedge clk);
    adly[0] = int'($urandom_range(0, 3));
    adly[1] = int'($urandom_range(0, 3));
    repeat (2) @(negedge clk);
    fork
      begin
        fork
          rand_run(0, 80);
          rand_run(1, 60);
        join
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(negedge clk);
          clr = ($urandom_range(0, 19) == 0);
        end
        clr = 1'b0;
      end
    join
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
